vector_lane_alu: RTL and testbench

VECTOR_LANE_ALU -- requirements
Module: vector_lane_alu

---
 rtl/vector_lane_alu.sv | 170 +++++++++++++++++
 tb/tb_vector_lane_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_alu.sv
// vector_lane_alu
//   Sequential vector ALU. A start in IDLE captures up to LANES element pairs,
//   then the unit computes one lane per cycle (lane 0 upward). It finishes
//   with a single DONE cycle that pulses done and, for a non-empty vector,
//   asserts the register-file write enable we3.
//
//   Optional feature: define VECTOR_LANE_ALU_MUL_EN to build a per-lane
//   multiplier for op=100. Without the macro, op=100 yields 0 in every
//   processed lane, and timing is unchanged.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        begin one vector operation (taken only in IDLE)
//   op[2:0]      000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 signed MIN,
//                11x pass A
//   vector_size  element count N; values above LANES are clamped to LANES
//   dst[3:0]     destination register index, returned on wa3
//   ain, bin     lane-packed operands, lane i = bits [W*i+W-1:W*i]
//   busy         high in RUN and DONE
//   done         one-cycle completion pulse
//   we3          write enable, high in the DONE cycle when N != 0
//   wa3[3:0]     dst captured at start
//   result       lane-packed results; lanes >= N read 0
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: start is sampled only while the FSM is in IDLE (busy=0). A start
// seen in RUN or DONE is dropped. It is not queued, and it does not touch the
// captured operands. busy rises on the edge that accepts start and falls on
// the edge that leaves DONE.
module vector_lane_alu #(
    parameter int LANES = 5,
    parameter int W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [2:0]         vector_size,
    input  logic [3:0]         dst,
    input  logic [LANES*W-1:0] ain,
    input  logic [LANES*W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic               we3,
    output logic [3:0]         wa3,
    output logic [LANES*W-1:0] result,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [LANES*W-1:0] a_q;
    logic [LANES*W-1:0] b_q;
    logic [2:0]         op_q;
    logic [2:0]         n_q;
    logic [2:0]         idx;

    logic [2:0]         n_eff;
    logic [W-1:0]       lane_a;
    logic [W-1:0]       lane_b;
    logic [W-1:0]       lane_res;

    assign state_dbg = state;

    // vector_size is only 3 bits wide. The clamp can therefore only trigger
    // when LANES < 7.
    always_comb begin
        n_eff = vector_size;
        if (int'(vector_size) > LANES) n_eff = 3'(LANES);
    end

    // Mux out the operand pair for the lane currently being processed.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (int'(idx) == i) begin
                lane_a = a_q[i*W +: W];
                lane_b = b_q[i*W +: W];
            end
        end
    end

    always_comb begin
        lane_res = '0;
        case (op_q)
            3'b000: lane_res = lane_a + lane_b;
            3'b001: lane_res = lane_a - lane_b;
            3'b010: lane_res = lane_a & lane_b;
            3'b011: lane_res = lane_a | lane_b;
`ifdef VECTOR_LANE_ALU_MUL_EN
            3'b100: lane_res = lane_a * lane_b;
`else
            3'b100: lane_res = '0;
`endif
            3'b101: lane_res = ($signed(lane_a) < $signed(lane_b)) ? lane_a : lane_b;
            default: lane_res = lane_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            n_q    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            we3    <= 1'b0;
            wa3    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    we3  <= 1'b0;
                    if (start) begin
                        a_q    <= ain;
                        b_q    <= bin;
                        op_q   <= op;
                        n_q    <= n_eff;
                        wa3    <= dst;
                        result <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        if (n_eff == 3'd0) begin
                            // An empty vector skips RUN. It completes without a write.
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (int'(idx) == i) result[i*W +: W] <= lane_res;
                    end
                    idx <= idx + 3'd1;
                    if (idx == n_q - 3'd1) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        we3   <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    we3   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    we3   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lane_alu.sv
module tb_vector_lane_alu;

    localparam int LANES = 5;
    localparam int W     = 32;
    localparam int LW    = LANES * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [2:0]    vector_size;
    logic [3:0]    dst;
    logic [LW-1:0] ain;
    logic [LW-1:0] bin;
    logic          busy;
    logic          done;
    logic          we3;
    logic [3:0]    wa3;
    logic [LW-1:0] result;
    logic [1:0]    state_dbg;

    logic [LW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    vector_lane_alu #(.LANES(LANES), .W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .vector_size(vector_size), .dst(dst), .ain(ain), .bin(bin),
        .busy(busy), .done(done), .we3(we3), .wa3(wa3),
        .result(result), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [LW-1:0] pack5(input logic [W-1:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic int eff_n(input logic [2:0] vs);
        return (int'(vs) > LANES) ? LANES : int'(vs);
    endfunction

    // Reference lane model used for the random operations.
    function automatic logic [LW-1:0] model(input logic [2:0] o, input logic [2:0] vs,
                                            input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [LW-1:0] r;
        logic [W-1:0]  x, y, z;
        r = '0;
        for (int i = 0; i < eff_n(vs); i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            case (o)
                3'd0: z = x + y;
                3'd1: z = x + ~y + 1;
                3'd2: z = x & y;
                3'd3: z = x | y;
`ifdef VECTOR_LANE_ALU_MUL_EN
                3'd4: z = W'(x * y);
`else
                3'd4: z = '0;
`endif
                3'd5: begin
                    if (x[W-1] != y[W-1]) z = x[W-1] ? x : y;
                    else                  z = (x < y) ? x : y;
                end
                default: z = x;
            endcase
            r[i*W +: W] = z;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: push the expected result, pulse start, wait for done and check it.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] vs,
                          input logic [3:0] d, input logic [LW-1:0] a, input logic [LW-1:0] b,
                          input logic [LW-1:0] expv);
        logic [LW-1:0] e;
        int            cyc;
        exp_q.push_back(expv);
        op = o; vector_size = vs; dst = d; ain = a; bin = b; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, LW'(busy), LW'(1));
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, LW'(cyc), LW'(eff_n(vs)));
        chk({tag, "_done"}, LW'(done), LW'(1));
        chk({tag, "_we3"}, LW'(we3), LW'(eff_n(vs) != 0));
        chk({tag, "_wa3"}, LW'(wa3), LW'(d));
        chk({tag, "_result"}, result, e);
        tick();
        chk({tag, "_done_low"}, LW'({done, we3, busy}), LW'(0));
        chk({tag, "_hold"}, result, e);
        chk({tag, "_wa3_hold"}, LW'(wa3), LW'(d));
    endtask

    initial begin
        logic [LW-1:0] ra, rb;
        logic [2:0]    rop, rvs;
        int            cyc, pulses, we_cnt;

        reset = 1'b1; start = 1'b0; op = '0; vector_size = '0; dst = '0; ain = '0; bin = '0;
        tick();
        tick();
        chk("reset_flags", LW'({busy, done, we3}), LW'(0));
        chk("reset_wa3", LW'(wa3), LW'(0));
        chk("reset_result", result, '0);
        chk("reset_state", LW'(state_dbg), LW'(0));
        reset = 1'b0;
        tick();

        // ADD, N=5
        run_op("add", 3'b000, 3'd5, 4'd9, pack5(1, 2, 3, 4, 5), pack5(10, 20, 30, 40, 50),
               pack5(11, 22, 33, 44, 55));

        // SUB wrap, then signed MIN
        run_op("sub_wrap", 3'b001, 3'd2, 4'd3, '0, pack5(1, 1, 1, 1, 1),
               pack5(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0));
        run_op("min_signed", 3'b101, 3'd1, 4'd4, pack5(32'hFFFF_FFFF, 7, 7, 7, 7),
               pack5(3, 1, 1, 1, 1), pack5(32'hFFFF_FFFF, 0, 0, 0, 0));

        // size boundaries
        run_op("size0", 3'b000, 3'd0, 4'd1, pack5(5, 5, 5, 5, 5), pack5(5, 5, 5, 5, 5), '0);
        run_op("size7", 3'b011, 3'd7, 4'd15, pack5(1, 2, 4, 8, 16), pack5(16, 8, 4, 2, 1),
               pack5(17, 10, 4, 10, 17));

        // AND, and pass A with op 110
        run_op("and", 3'b010, 3'd3, 4'd6, pack5(32'hF0F0, 32'hFF, 32'h1234, 9, 9),
               pack5(32'h0FF0, 32'h0F, 32'h00FF, 9, 9), pack5(32'h00F0, 32'h0F, 32'h0034, 0, 0));
        run_op("passa", 3'b110, 3'd4, 4'd2, pack5(7, 8, 9, 10, 11), pack5(1, 1, 1, 1, 1),
               pack5(7, 8, 9, 10, 0));

        // MUL
        run_op("mul_wrap", 3'b100, 3'd1, 4'd5, pack5(32'h10000, 0, 0, 0, 0),
               pack5(32'h10000, 0, 0, 0, 0), '0);
`ifdef VECTOR_LANE_ALU_MUL_EN
        run_op("mul_3x7", 3'b100, 3'd1, 4'd5, pack5(3, 0, 0, 0, 0), pack5(7, 0, 0, 0, 0),
               pack5(21, 0, 0, 0, 0));
`else
        run_op("mul_3x7", 3'b100, 3'd1, 4'd5, pack5(3, 0, 0, 0, 0), pack5(7, 0, 0, 0, 0), '0);
`endif

        // Start is held through the whole run, and ain/op change mid-run.
        exp_q.push_back(pack5(3, 6, 9, 12, 15));
        op = 3'b000; vector_size = 3'd5; dst = 4'd11;
        ain = pack5(2, 4, 6, 8, 10); bin = pack5(1, 2, 3, 4, 5); start = 1'b1;
        tick();
        cyc = 0; pulses = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 2) begin
                ain = {LANES{32'h0000_00FF}};
                op  = 3'b001;
            end
        end
        pulses += done;
        chk("hold_latency", LW'(cyc), LW'(5));
        chk("hold_result", result, exp_q.pop_front());
        tick();
        chk("hold_start_in_done_ignored", LW'({busy, done}), LW'(0));
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            pulses += done;
        end
        chk("hold_single_pulse", LW'(pulses), LW'(1));
        run_op("after_hold", 3'b000, 3'd2, 4'd12, pack5(100, 200, 0, 0, 0),
               pack5(1, 2, 0, 0, 0), pack5(101, 202, 0, 0, 0));

        // Reset asserted during the second cycle of an N=4 run.
        op = 3'b000; vector_size = 3'd4; dst = 4'd7;
        ain = pack5(1, 1, 1, 1, 1); bin = pack5(1, 1, 1, 1, 1); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("abort_flags", LW'({busy, done, we3}), LW'(0));
        chk("abort_result", result, '0);
        chk("abort_wa3", LW'(wa3), LW'(0));
        reset = 1'b0;
        we_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            we_cnt += we3;
        end
        chk("abort_no_we3", LW'(we_cnt), LW'(0));

        // Random operations, checked against the reference model.
        for (int t = 0; t < 6; t++) begin
            rop = 3'($urandom_range(0, 7));
            rvs = 3'($urandom_range(0, 7));
            for (int i = 0; i < LANES; i++) begin
                ra[i*W +: W] = $urandom;
                rb[i*W +: W] = $urandom;
            end
            run_op("random", rop, rvs, 4'($urandom_range(0, 15)), ra, rb, model(rop, rvs, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
